// File: rtl/ftdi_pkg.sv
// Shared FTDI UART definitions: FSM state codes (common to rx and tx debug views) and baud step math.
package ftdi_pkg;

  localparam longint unsigned OVERSAMPLE = 64'd16;
  localparam int unsigned     BYTE_W     = 8;
  localparam int unsigned     STATE_W    = 3;

  typedef logic [BYTE_W-1:0] ftdi_byte_t;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } ftdi_state_e;

  // Phase-accumulator step, evaluated in 64 bits to avoid overflow of baud*mult<<width.
  function automatic longint unsigned calc_inc(input longint unsigned freq,
                                               input longint unsigned baud,
                                               input longint unsigned mult,
                                               input int unsigned     acc_w);
    return ((baud * mult) << acc_w) / freq;
  endfunction

endpackage

// File: rtl/ftdi_uart_rx_if.sv
// Received-byte valid/ready handshake between the UART receiver and its consumer.
interface ftdi_uart_rx_if;
  import ftdi_pkg::*;

  ftdi_byte_t data;
  logic       data_valid;
  logic       data_ready;

  modport master (output data, output data_valid, input  data_ready);
  modport slave  (input  data, input  data_valid, output data_ready);
endinterface

// File: rtl/ftdi_baud_gen.sv
// Phase-accumulator tick generator: one-cycle tick at BAUD_RATE*MULT ticks per second.
module ftdi_baud_gen
  import ftdi_pkg::*;
#(
  parameter longint unsigned FREQUENCY = 64'd50_000_000,
  parameter longint unsigned BAUD_RATE = 64'd115200,
  parameter int unsigned     ACC_WIDTH = 16,
  parameter longint unsigned MULT      = OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam longint unsigned   INC_FULL = calc_inc(FREQUENCY, BAUD_RATE, MULT, ACC_WIDTH);
  localparam logic [ACC_WIDTH:0] INC     = (ACC_WIDTH+1)'(INC_FULL);

  logic [ACC_WIDTH:0] r_acc;

  // Carry out of the low ACC_WIDTH bits is the tick; it is dropped on the next add.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_acc <= '0;
    else       r_acc <= {1'b0, r_acc[ACC_WIDTH-1:0]} + INC;
  end

  assign o_tick = r_acc[ACC_WIDTH];

endmodule

// File: rtl/ftdi_uart_rx.sv
// FTDI serial receiver: 16x oversampled 8N1 deframer with a one-entry holding register.
// Defining FTDI_UART_RX_PARITY_EN switches the frame to 8E1 and enables parity_error.
module ftdi_uart_rx
  import ftdi_pkg::*;
#(
  parameter longint unsigned FREQUENCY = 64'd50_000_000,
  parameter longint unsigned BAUD_RATE = 64'd115200,
  parameter int unsigned     ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 FTDI_TX,
  output logic                 FTDI_RTS,
  ftdi_uart_rx_if.master       rx_bus,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 parity_error,
  output logic [STATE_W-1:0]   state_test
);

  logic [1:0]  r_sync;
  logic        w_rxs;
  logic        w_tick;
  logic        w_mid_bit;
  logic        w_transfer;

  ftdi_state_e r_state,      w_state_nxt;
  logic [3:0]  r_sample_cnt, w_sample_cnt_nxt;
  logic [2:0]  r_bit_cnt,    w_bit_cnt_nxt;
  ftdi_byte_t  r_shift,      w_shift_nxt;
  logic        w_deliver;
  logic        w_ferr;

  ftdi_byte_t  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        r_ovr;

`ifdef FTDI_UART_RX_PARITY_EN
  logic        r_par_bad, w_par_bad_nxt;
  logic        w_perr;
  logic        r_perr;
`endif

  ftdi_baud_gen #(
    .FREQUENCY (FREQUENCY),
    .BAUD_RATE (BAUD_RATE),
    .ACC_WIDTH (ACC_WIDTH),
    .MULT      (OVERSAMPLE)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], FTDI_TX};
  end

  assign w_rxs      = r_sync[1];
  assign w_mid_bit  = w_tick && (r_sample_cnt == 4'd15);
  assign w_transfer = r_valid && rx_bus.data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
`ifdef FTDI_UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_sample_cnt <= w_sample_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
`ifdef FTDI_UART_RX_PARITY_EN
      r_par_bad    <= w_par_bad_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sample_cnt_nxt = r_sample_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_deliver        = 1'b0;
    w_ferr           = 1'b0;
`ifdef FTDI_UART_RX_PARITY_EN
    w_par_bad_nxt    = r_par_bad;
    w_perr           = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt      = ST_START;
          w_sample_cnt_nxt = '0;
        end
      end
      // Re-check the line at mid start bit so short low glitches are ignored.
      ST_START: begin
        if (w_tick) begin
          if (r_sample_cnt == 4'd7) begin
            w_sample_cnt_nxt = '0;
            w_bit_cnt_nxt    = '0;
            w_state_nxt      = w_rxs ? ST_IDLE : ST_DATA;
`ifdef FTDI_UART_RX_PARITY_EN
            w_par_bad_nxt    = 1'b0;
`endif
          end else begin
            w_sample_cnt_nxt = r_sample_cnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) w_sample_cnt_nxt = r_sample_cnt + 4'd1;
        if (w_mid_bit) begin
          w_shift_nxt   = {w_rxs, r_shift[BYTE_W-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
`ifdef FTDI_UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
      ST_PARITY: begin
`ifdef FTDI_UART_RX_PARITY_EN
        if (w_tick) w_sample_cnt_nxt = r_sample_cnt + 4'd1;
        if (w_mid_bit) begin
          w_par_bad_nxt = (w_rxs != ^r_shift);
          w_state_nxt   = ST_STOP;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (w_tick) w_sample_cnt_nxt = r_sample_cnt + 4'd1;
        if (w_mid_bit) begin
`ifdef FTDI_UART_RX_PARITY_EN
          w_perr = r_par_bad;
          w_deliver = w_rxs && !r_par_bad;
`else
          w_deliver = w_rxs;
`endif
          w_ferr      = !w_rxs;
          w_state_nxt = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      // Hold off during a break until the line returns high.
      ST_WAIT_HIGH: begin
        if (w_tick && w_rxs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One-entry holding register; a byte arriving while full and not drained is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || w_transfer) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_transfer) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef FTDI_UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_perr <= 1'b0;
    else       r_perr <= w_perr;
  end
  assign parity_error = r_perr;
`else
  assign parity_error = 1'b0;
`endif

  assign rx_bus.data       = r_data;
  assign rx_bus.data_valid = r_valid;
  assign FTDI_RTS          = ~r_valid;
  assign framing_error     = r_ferr;
  assign overrun           = r_ovr;
  assign state_test        = r_state;

endmodule

// File: tb/tb_ftdi_uart_rx.sv
// Directed bench for ftdi_uart_rx at 32 clk per bit (FREQUENCY=32, BAUD_RATE=1, ACC_WIDTH=4).
// Build with FTDI_UART_RX_PARITY_EN defined to exercise the 8E1 frame.
module tb_ftdi_uart_rx;

  localparam int BIT_CLK = 32;

  logic       clk;
  logic       reset;
  logic       tx;
  logic       rts;
  logic       fe;
  logic       ovr;
  logic       perr;
  logic [2:0] st;

  ftdi_uart_rx_if bus();

  ftdi_uart_rx #(
    .FREQUENCY (64'd32),
    .BAUD_RATE (64'd1),
    .ACC_WIDTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .FTDI_TX       (tx),
    .FTDI_RTS      (rts),
    .rx_bus        (bus),
    .framing_error (fe),
    .overrun       (ovr),
    .parity_error  (perr),
    .state_test    (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Running event counters sampled on the falling edge.
  int         valid_cyc = 0;
  int         fe_cnt    = 0;
  int         ovr_cnt   = 0;
  int         perr_cnt  = 0;
  int         rts_bad   = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) valid_cyc++;
    if (bus.data_valid === 1'b1 && prev_valid !== 1'b1) last_data = bus.data;
    if (fe === 1'b1)   fe_cnt++;
    if (ovr === 1'b1)  ovr_cnt++;
    if (perr === 1'b1) perr_cnt++;
    if (rts !== ~bus.data_valid) rts_bad++;
    prev_valid = bus.data_valid;
  end

  int s_valid, s_fe, s_ovr, s_perr;

  task automatic snap();
    s_valid = valid_cyc;
    s_fe    = fe_cnt;
    s_ovr   = ovr_cnt;
    s_perr  = perr_cnt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    tx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] d);
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(d[i], BIT_CLK);
  endtask

  // Full frame; parity (when compiled in) is the correct even-parity bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len, input int idle_len);
    send_bits(d);
`ifdef FTDI_UART_RX_PARITY_EN
    drive(^d, BIT_CLK);
`endif
    drive(stop_v, stop_len);
    drive(1'b1, idle_len);
  endtask

`ifdef FTDI_UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bits(d);
    drive(par, BIT_CLK);
    drive(1'b1, BIT_CLK);
    drive(1'b1, 40);
  endtask
`endif

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_fe;
    int         exp_ovr;
  } frame_vec_t;

  frame_vec_t vecs[4];

  initial begin
    vecs[0] = '{din: 8'hA5, exp_data: 8'hA5, exp_valid: 1, exp_fe: 0, exp_ovr: 0};
    vecs[1] = '{din: 8'h00, exp_data: 8'h00, exp_valid: 1, exp_fe: 0, exp_ovr: 0};
    vecs[2] = '{din: 8'hFF, exp_data: 8'hFF, exp_valid: 1, exp_fe: 0, exp_ovr: 0};
    vecs[3] = '{din: 8'h81, exp_data: 8'h81, exp_valid: 1, exp_fe: 0, exp_ovr: 0};

    reset = 1'b0;
    tx    = 1'b1;
    bus.data_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("reset_data",  32'(bus.data),       32'h00);
    check("reset_valid", 32'(bus.data_valid), 32'h0);
    check("reset_rts",   32'(rts),            32'h1);
    check("reset_fe",    32'(fe),             32'h0);
    check("reset_ovr",   32'(ovr),            32'h0);
    check("reset_perr",  32'(perr),           32'h0);
    check("reset_state", 32'(st),             32'h0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Clean frames drained immediately by the consumer.
    for (int i = 0; i < 4; i++) begin
      snap();
      send_frame(vecs[i].din, 1'b1, BIT_CLK, 40);
      check($sformatf("vec%0d_data", i),  32'(last_data),    32'(vecs[i].exp_data));
      check($sformatf("vec%0d_valid", i), 32'(valid_cyc - s_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_fe", i),    32'(fe_cnt - s_fe),       32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_ovr", i),   32'(ovr_cnt - s_ovr),     32'(vecs[i].exp_ovr));
      check($sformatf("vec%0d_state", i), 32'(st),                  32'h0);
      check($sformatf("vec%0d_rts", i),   32'(rts),                 32'h1);
    end

    // Short low glitch: rejected at mid start bit.
    snap();
    drive(1'b0, 8);
    drive(1'b1, 64);
    check("glitch_state", 32'(st),                  32'h0);
    check("glitch_valid", 32'(valid_cyc - s_valid), 32'h0);
    check("glitch_fe",    32'(fe_cnt - s_fe),       32'h0);

    // Bad stop bit followed by a break, then a clean frame.
    snap();
    send_frame(8'h3C, 1'b0, 64, 64);
    check("break_fe",    32'(fe_cnt - s_fe),       32'h1);
    check("break_valid", 32'(valid_cyc - s_valid), 32'h0);
    check("break_state", 32'(st),                  32'h0);
    snap();
    send_frame(8'h3C, 1'b1, BIT_CLK, 40);
    check("after_break_data",  32'(last_data),            32'h3C);
    check("after_break_valid", 32'(valid_cyc - s_valid),  32'h1);
    check("after_break_fe",    32'(fe_cnt - s_fe),        32'h0);

    // Consumer stalled: second byte overruns.
    bus.data_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, BIT_CLK, 40);
    check("stall1_data",  32'(bus.data),       32'h11);
    check("stall1_valid", 32'(bus.data_valid), 32'h1);
    check("stall1_rts",   32'(rts),            32'h0);
    send_frame(8'h22, 1'b1, BIT_CLK, 40);
    check("stall2_data",  32'(bus.data),       32'h11);
    check("stall2_valid", 32'(bus.data_valid), 32'h1);
    check("stall2_ovr",   32'(ovr_cnt - s_ovr), 32'h1);
    check("stall2_rts",   32'(rts),            32'h0);

    // Reset in the middle of bit 4 of 0xFF, with the holding register still full.
    send_bits_partial();
    check("mid_state", 32'(st), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("async_data",  32'(bus.data),       32'h00);
    check("async_valid", 32'(bus.data_valid), 32'h0);
    check("async_rts",   32'(rts),            32'h1);
    check("async_state", 32'(st),             32'h0);
    check("async_ovr",   32'(ovr),            32'h0);
    tx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.data_ready = 1'b1;
    repeat (8) @(negedge clk);
    snap();
    send_frame(8'h5A, 1'b1, BIT_CLK, 40);
    check("post_reset_data",  32'(last_data),           32'h5A);
    check("post_reset_valid", 32'(valid_cyc - s_valid), 32'h1);
    check("post_reset_ovr",   32'(ovr_cnt - s_ovr),     32'h0);

`ifdef FTDI_UART_RX_PARITY_EN
    snap();
    send_frame_par(8'h07, 1'b1);
    check("par_ok_data",  32'(last_data),           32'h07);
    check("par_ok_valid", 32'(valid_cyc - s_valid), 32'h1);
    check("par_ok_perr",  32'(perr_cnt - s_perr),   32'h0);
    snap();
    send_frame_par(8'h07, 1'b0);
    check("par_bad_perr",  32'(perr_cnt - s_perr),   32'h1);
    check("par_bad_valid", 32'(valid_cyc - s_valid), 32'h0);
    check("par_bad_fe",    32'(fe_cnt - s_fe),       32'h0);
`else
    check("perr_never", 32'(perr_cnt), 32'h0);
`endif

    check("rts_tracks_valid", 32'(rts_bad), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Start bit plus bits 0-3 of 0xFF, then half of bit 4.
  task automatic send_bits_partial();
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(1'b1, BIT_CLK);
    drive(1'b1, BIT_CLK / 2);
  endtask

endmodule
